ch_mover: RTL and testbench

//  Channel-side data mover: the consumer of a channel's m_src FIFO and the producer of its m_dst FIFO.

---
 rtl/ch_mover.sv | 162 ++++++++++++++++
 tb/tb_ch_mover.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ch_mover.sv
// ch_mover: channel-side data mover.
// Consumes words from the channel's show-ahead source FIFO and produces words
// into its destination FIFO. Each descriptor selects copy, fill-zero or
// check-zero. A descriptor ends on the source last-word or on a word limit,
// and the end of buffer is then signalled on m_endn.
//
// FIFO handshake: m_src_getn and m_dst_putn are active-low strobes. A word
// moves in any cycle where the strobe is low at the rising clock edge. The
// mover lowers a strobe only when the matching FIFO flag (m_src_empty or
// m_dst_full) allows the move in that same cycle. In copy mode both strobes
// fall together or not at all, so a word is never popped without being pushed.
module ch_mover #(
  parameter int CW = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          start,
  input  logic          abort,
  input  logic [23:0]   dc,
  input  logic [63:0]   m_src,
  input  logic          m_src_last,
  input  logic          m_src_empty,
  input  logic          m_dst_full,
  output logic          m_src_getn,
  output logic          m_dst_putn,
  output logic [63:0]   m_dst,
  output logic          m_dst_last,
  output logic          m_endn,
  output logic          m_reset,
  output logic [CW-1:0] ocnt,
  output logic          busy,
  output logic          done,
  output logic [2:0]    status,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ENDS = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lim_q;
  logic [1:0]  op_q;
  logic        is_fill, is_check, is_copy;
  logic        xfer, term, lim_hit;
  logic [CW:0] ocnt_inc;
  logic [CW:0] lim_ext;
  logic        unused_dc;

  // Bits above the op field carry nothing for this block.
  assign unused_dc = ^dc[23:18];

  assign state_dbg = state_q;
  assign is_fill   = (op_q == 2'b01);
  assign is_check  = (op_q == 2'b10);
  assign is_copy   = !is_fill && !is_check;  // 00 and 11 both copy
  assign ocnt_inc  = {1'b0, ocnt} + (CW+1)'(1);
  assign lim_ext   = (CW+1)'(lim_q);
  assign lim_hit   = (lim_q != 16'd0) && (ocnt_inc == lim_ext);

  // Next state and the combinational FIFO strobes and write data.
  always_comb begin
    state_d    = state_q;
    xfer       = 1'b0;
    term       = 1'b0;
    m_src_getn = 1'b1;
    m_dst_putn = 1'b1;
    m_dst      = 64'd0;
    m_dst_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (abort) begin
          // A cancelled descriptor moves no further words, even in its last cycle.
          state_d = IDLE;
        end else begin
          if (is_copy) begin
            xfer       = !m_src_empty && !m_dst_full;
            m_src_getn = !xfer;
            m_dst_putn = !xfer;
            m_dst      = xfer ? m_src : 64'd0;
          end else if (is_fill) begin
            // A fill with no limit has nothing to write.
            xfer       = !m_dst_full && (lim_q != 16'd0);
            m_dst_putn = !xfer;
          end else begin
            xfer       = !m_src_empty;
            m_src_getn = !xfer;
          end
          term       = xfer && (lim_hit || (!is_fill && m_src_last));
          m_dst_last = term && !is_check;
          if (term || (is_fill && lim_q == 16'd0)) state_d = ENDS;
        end
      end
      ENDS: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, descriptor latch, counter, status and registered pulse outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      lim_q   <= 16'd0;
      op_q    <= 2'b00;
      ocnt    <= '0;
      status  <= 3'b000;
      m_endn  <= 1'b1;
      m_reset <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      m_endn  <= 1'b1;
      m_reset <= 1'b0;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start in IDLE takes priority over a simultaneous abort.
          if (start) begin
            lim_q  <= dc[15:0];
            op_q   <= dc[17:16];
            ocnt   <= '0;
            status <= 3'b000;
          end
        end
        RUN: begin
          if (abort) begin
            m_reset   <= 1'b1;
            done      <= 1'b1;
            status[0] <= 1'b1;
          end else begin
            if (xfer && (ocnt != {CW{1'b1}})) ocnt <= ocnt_inc[CW-1:0];
            if (xfer && is_check && (m_src != 64'd0)) status[2] <= 1'b1;
            if (term && !is_fill && m_src_last && (lim_q != 16'd0) && !lim_hit)
              status[1] <= 1'b1;
            if (state_d == ENDS) begin
              m_endn <= 1'b0;
              done   <= 1'b1;
            end
          end
        end
        ENDS: begin
          if (abort) begin
            m_reset   <= 1'b1;
            done      <= 1'b1;
            status[0] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ch_mover.sv
// tb_ch_mover: scenario bench for ch_mover with a modelled source FIFO and a
// scoreboard of expected destination pushes {last, data}.
module tb_ch_mover;

  localparam int CW = 16;

  logic          clk;
  logic          wb_rst_ni;
  logic          start;
  logic          abort;
  logic [23:0]   dc;
  logic [63:0]   m_src;
  logic          m_src_last;
  logic          m_src_empty;
  logic          m_dst_full;
  logic          m_src_getn;
  logic          m_dst_putn;
  logic [63:0]   m_dst;
  logic          m_dst_last;
  logic          m_endn;
  logic          m_reset;
  logic [CW-1:0] ocnt;
  logic          busy;
  logic          done;
  logic [2:0]    status;
  logic [1:0]    state_dbg;

  ch_mover #(.CW(CW)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (wb_rst_ni),
    .start       (start),
    .abort       (abort),
    .dc          (dc),
    .m_src       (m_src),
    .m_src_last  (m_src_last),
    .m_src_empty (m_src_empty),
    .m_dst_full  (m_dst_full),
    .m_src_getn  (m_src_getn),
    .m_dst_putn  (m_dst_putn),
    .m_dst       (m_dst),
    .m_dst_last  (m_dst_last),
    .m_endn      (m_endn),
    .m_reset     (m_reset),
    .ocnt        (ocnt),
    .busy        (busy),
    .done        (done),
    .status      (status),
    .state_dbg   (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [64:0] exp_q[$];
  logic [63:0] src_d[$];
  logic        src_l[$];

  int n_pop, n_push, n_done, n_endn, n_mreset, done_at, cur_c;

  task automatic clear_src();
    src_d.delete();
    src_l.delete();
  endtask

  task automatic add_word(input logic [63:0] d, input logic l);
    src_d.push_back(d);
    src_l.push_back(l);
  endtask

  task automatic add_rand(input int n, input int last_at);
    for (int i = 1; i <= n; i++) add_word({$urandom, $urandom} | 64'h1, i == last_at);
  endtask

  // Expected copy pushes derived from the loaded source words.
  task automatic exp_copy(input logic [15:0] lim);
    for (int i = 0; i < src_d.size(); i++) begin
      logic t;
      t = ((lim != 16'd0) && (i + 1 == int'(lim))) || src_l[i];
      exp_q.push_back({t, src_d[i]});
      if (t) break;
    end
  endtask

  task automatic exp_fill(input int lim);
    for (int i = 0; i < lim; i++) exp_q.push_back({i == lim - 1, 64'd0});
  endtask

  // One clock: drive FIFO model, sample at negedge, retire pops after posedge.
  task automatic step(input bit full, input bit ab);
    bit   pop;
    logic [64:0] e;
    m_src_empty = (src_d.size() == 0);
    m_src       = m_src_empty ? 64'd0 : src_d[0];
    m_src_last  = m_src_empty ? 1'b0 : src_l[0];
    m_dst_full  = full;
    abort       = ab;
    @(negedge clk);
    pop = !m_src_getn;
    total++;
    if ((!m_src_getn && m_src_empty) || (!m_dst_putn && m_dst_full)) begin
      bad++;
      $display("FAIL blocked_strobe c=%0d getn=%b empty=%b putn=%b full=%b", cur_c, m_src_getn, m_src_empty, m_dst_putn, m_dst_full);
    end
    if (pop) n_pop++;
    if (!m_dst_putn) begin
      n_push++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL push_unexpected c=%0d got=%h last=%b want=none", cur_c, m_dst, m_dst_last);
      end else begin
        e = exp_q.pop_front();
        if ({m_dst_last, m_dst} !== e) begin
          bad++;
          $display("FAIL push_data c=%0d got=%b_%h want=%b_%h", cur_c, m_dst_last, m_dst, e[64], e[63:0]);
        end
      end
    end
    if (done === 1'b1) begin
      n_done++;
      if (done_at < 0) done_at = cur_c;
    end
    if (m_endn === 1'b0) n_endn++;
    if (m_reset === 1'b1) n_mreset++;
    @(posedge clk);
    #1;
    abort = 1'b0;
    if (pop && src_d.size() > 0) begin
      void'(src_d.pop_front());
      void'(src_l.pop_front());
    end
  endtask

  // Start a descriptor and clock it until done, plus one trailing cycle.
  task automatic run_desc(input logic [1:0] op, input logic [15:0] lim, input bit ab0,
                          input int ab_at, input int f_lo, input int f_hi);
    n_pop = 0; n_push = 0; n_done = 0; n_endn = 0; n_mreset = 0; done_at = -1;
    cur_c = 0;
    start = 1'b1;
    dc    = {6'd0, op, lim};
    step(1'b0, ab0);
    start = 1'b0;
    dc    = 24'd0;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      cur_c = c;
      step(c >= f_lo && c <= f_hi, c == ab_at);
    end
    total++;
    if (done_at < 0) begin
      bad++;
      $display("FAIL desc_timeout got=no_done want=done_within_40");
    end
    cur_c = 99;
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    wb_rst_ni = 1'b0; start = 1'b0; abort = 1'b0; dc = 24'd0;
    m_src = 64'd0; m_src_last = 1'b0; m_src_empty = 1'b1; m_dst_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({m_src_getn, m_dst_putn, m_endn, m_reset, busy, done, m_dst_last, status, state_dbg} !== 12'b111_0000_000_00) begin
      bad++;
      $display("FAIL reset_flags got=%b want=%b", {m_src_getn, m_dst_putn, m_endn, m_reset, busy, done, m_dst_last, status, state_dbg}, 12'b111_0000_000_00);
    end
    total++;
    if (m_dst !== 64'd0 || ocnt !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%0d want=0/0", m_dst, ocnt);
    end
    @(negedge clk);
    wb_rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_copy_last();
    clear_src(); add_rand(4, 4); exp_copy(16'd0);
    run_desc(2'b00, 16'd0, 1'b0, 0, 0, 0);
    total++; if (done_at !== 5) begin bad++; $display("FAIL copy_done_at got=%0d want=5", done_at); end
    total++; if (n_pop !== 4 || n_push !== 4) begin bad++; $display("FAIL copy_counts got=%0d/%0d want=4/4", n_pop, n_push); end
    total++; if (n_endn !== 1 || n_done !== 1) begin bad++; $display("FAIL copy_end got=%0d/%0d want=1/1", n_endn, n_done); end
    total++; if (ocnt !== 16'd4 || status !== 3'b000) begin bad++; $display("FAIL copy_ocnt_status got=%0d/%b want=4/000", ocnt, status); end
    total++; if (exp_q.size() !== 0 || busy !== 1'b0) begin bad++; $display("FAIL copy_left got=%0d/%b want=0/0", exp_q.size(), busy); end
  endtask

  task automatic test_dst_full();
    clear_src(); add_rand(4, 4); exp_copy(16'd0);
    run_desc(2'b11, 16'd0, 1'b0, 0, 2, 3);
    total++; if (done_at !== 7) begin bad++; $display("FAIL full_done_at got=%0d want=7", done_at); end
    total++; if (ocnt !== 16'd4 || n_pop !== 4 || exp_q.size() !== 0) begin bad++; $display("FAIL full_counts got=%0d/%0d/%0d want=4/4/0", ocnt, n_pop, exp_q.size()); end
  endtask

  task automatic test_limit();
    clear_src(); add_rand(5, 5); exp_copy(16'd3);
    run_desc(2'b00, 16'd3, 1'b0, 0, 0, 0);
    total++; if (done_at !== 4 || n_push !== 3) begin bad++; $display("FAIL limit_run got=%0d/%0d want=4/3", done_at, n_push); end
    total++; if (src_d.size() !== 2 || status !== 3'b000 || ocnt !== 16'd3) begin bad++; $display("FAIL limit_state got=%0d/%b/%0d want=2/000/3", src_d.size(), status, ocnt); end
    clear_src(); add_rand(2, 2); exp_copy(16'd8);
    run_desc(2'b00, 16'd8, 1'b0, 0, 0, 0);
    total++; if (status !== 3'b010 || ocnt !== 16'd2 || done_at !== 3) begin bad++; $display("FAIL short got=%b/%0d/%0d want=010/2/3", status, ocnt, done_at); end
  endtask

  task automatic test_fill();
    clear_src(); add_rand(1, 1); exp_fill(5);
    run_desc(2'b01, 16'd5, 1'b0, 0, 0, 0);
    total++; if (n_pop !== 0 || n_push !== 5 || done_at !== 6) begin bad++; $display("FAIL fill5 got=%0d/%0d/%0d want=0/5/6", n_pop, n_push, done_at); end
    total++; if (ocnt !== 16'd5 || status !== 3'b000 || n_endn !== 1) begin bad++; $display("FAIL fill5_state got=%0d/%b/%0d want=5/000/1", ocnt, status, n_endn); end
    clear_src();
    run_desc(2'b01, 16'd0, 1'b0, 0, 0, 0);
    total++; if (n_push !== 0 || done_at !== 2 || ocnt !== 16'd0) begin bad++; $display("FAIL fill0 got=%0d/%0d/%0d want=0/2/0", n_push, done_at, ocnt); end
  endtask

  task automatic test_check_zero();
    clear_src();
    add_word(64'd0, 1'b0); add_word(64'd1, 1'b0); add_word(64'd0, 1'b1);
    run_desc(2'b10, 16'd0, 1'b0, 0, 0, 0);
    total++; if (n_push !== 0 || n_pop !== 3) begin bad++; $display("FAIL check_strobes got=%0d/%0d want=0/3", n_push, n_pop); end
    total++; if (status !== 3'b100 || ocnt !== 16'd3 || done_at !== 4) begin bad++; $display("FAIL check_state got=%b/%0d/%0d want=100/3/4", status, ocnt, done_at); end
  endtask

  task automatic test_abort();
    clear_src(); add_rand(6, 0);
    exp_q.push_back({1'b0, src_d[0]});
    run_desc(2'b00, 16'd0, 1'b0, 2, 2, 2);
    total++; if (done_at !== 3 || n_mreset !== 1 || n_endn !== 0) begin bad++; $display("FAIL abort_pulses got=%0d/%0d/%0d want=3/1/0", done_at, n_mreset, n_endn); end
    total++; if (status !== 3'b001 || ocnt !== 16'd1 || busy !== 1'b0 || exp_q.size() !== 0) begin bad++; $display("FAIL abort_state got=%b/%0d/%b/%0d want=001/1/0/0", status, ocnt, busy, exp_q.size()); end
    clear_src(); exp_fill(1);
    run_desc(2'b01, 16'd1, 1'b1, 0, 0, 0);
    total++; if (done_at !== 2 || status !== 3'b000 || n_push !== 1 || n_mreset !== 0) begin bad++; $display("FAIL start_wins got=%0d/%b/%0d/%0d want=2/000/1/0", done_at, status, n_push, n_mreset); end
  endtask

  task automatic test_async_reset();
    clear_src(); add_rand(6, 0);
    exp_q.push_back({1'b0, src_d[0]});
    exp_q.push_back({1'b0, src_d[1]});
    n_pop = 0; n_push = 0; n_done = 0; n_endn = 0; n_mreset = 0; done_at = -1;
    start = 1'b1; dc = 24'd0; cur_c = 0;
    step(1'b0, 1'b0);
    start = 1'b0;
    for (int c = 1; c <= 2; c++) begin cur_c = c; step(1'b0, 1'b0); end
    total++; if (busy !== 1'b1 || ocnt !== 16'd2) begin bad++; $display("FAIL arst_pre got=%b/%0d want=1/2", busy, ocnt); end
    #2;
    wb_rst_ni = 1'b0;
    #1;
    total++;
    if ({m_src_getn, m_dst_putn, m_endn, m_reset, busy, done, m_dst_last, status, state_dbg} !== 12'b111_0000_000_00 || ocnt !== '0 || m_dst !== 64'd0) begin
      bad++;
      $display("FAIL arst_values got=%b/%0d want=%b/0", {m_src_getn, m_dst_putn, m_endn, m_reset, busy, done, m_dst_last, status, state_dbg}, ocnt, 12'b111_0000_000_00);
    end
    @(negedge clk);
    wb_rst_ni = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 3; c <= 5; c++) begin cur_c = c; step(1'b0, 1'b0); end
    total++; if (n_done !== 0 || n_endn !== 0 || n_pop !== 2 || exp_q.size() !== 0) begin bad++; $display("FAIL arst_post got=%0d/%0d/%0d/%0d want=0/0/2/0", n_done, n_endn, n_pop, exp_q.size()); end
    clear_src();
  endtask

  initial begin
    test_reset();
    test_copy_last();
    test_dst_full();
    test_limit();
    test_fill();
    test_check_zero();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
